// File: rtl/ws281x_ram_arb.sv
// Round-robin arbiter sharing one registered-output pixel RAM between a host
// write port (absolute priority) and CH_N WS281x channel read ports.

module ws281x_ram_arb_ch (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic req,
    input  logic en,
    input  logic gnt,
    input  logic ack,
    output logic pending,
    output logic elig
);
    assign elig = req & en & ~pending;

    // A grant can never coincide with this channel's ack: elig excludes pending.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)  pending <= 1'b0;
        else if (gnt)   pending <= 1'b1;
        else if (ack)   pending <= 1'b0;
    end
endmodule

module ws281x_ram_arb #(
    parameter  int CH_N = 4,
    parameter  int AW   = 6,
    parameter  int DW   = 32,
    localparam int CHW  = $clog2(CH_N)
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 wr_en_in,
    input  logic [CHW+AW-1:0]    wr_addr_in,
    input  logic [DW-1:0]        wr_data_in,
    input  logic [CH_N-1:0]      ch_en_in,
    input  logic [CH_N-1:0]      rd_req_in,
    input  logic [CH_N*AW-1:0]   rd_addr_in,
    output logic [CH_N-1:0]      rd_ack_out,
    output logic [DW-1:0]        rd_data_out,
    output logic                 ram_wr_en_out,
    output logic                 ram_rd_en_out,
    output logic [CHW+AW-1:0]    ram_addr_out,
    output logic [DW-1:0]        ram_wr_data_out,
    input  logic [DW-1:0]        ram_rd_data_in
);
    localparam int STAGES = 2;

    logic [CH_N-1:0]             pending;
    logic [CH_N-1:0]             elig;
    logic [CH_N-1:0]             gnt_oh;
    logic [CHW-1:0]              rr_ptr;
    logic [CHW-1:0]              gnt_idx;
    logic [CHW-1:0]              cand;
    logic                        gnt_vld;
    logic                        rd_gnt;
    logic [STAGES:1]             vld_pipe;
    logic [STAGES:1][CHW-1:0]    tag_pipe;

    genvar gi;
    generate
        for (gi = 0; gi < CH_N; gi++) begin : g_ch
            ws281x_ram_arb_ch u_ch (
                .clk_in   (clk_in),
                .rst_n_in (rst_n_in),
                .req      (rd_req_in[gi]),
                .en       (ch_en_in[gi]),
                .gnt      (gnt_oh[gi]),
                .ack      (rd_ack_out[gi]),
                .pending  (pending[gi]),
                .elig     (elig[gi])
            );
        end
    endgenerate

    // First eligible channel searching upward from rr_ptr+1 with wrap.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 1; k <= CH_N; k++) begin
            cand = CHW'((int'(rr_ptr) + k) % CH_N);
            if (!gnt_vld && elig[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign rd_gnt = gnt_vld & ~wr_en_in;
    assign gnt_oh = rd_gnt ? (CH_N'(1) << gnt_idx) : '0;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rr_ptr          <= CHW'(CH_N - 1);
            vld_pipe        <= '0;
            tag_pipe        <= '0;
            ram_wr_en_out   <= 1'b0;
            ram_rd_en_out   <= 1'b0;
            ram_addr_out    <= '0;
            ram_wr_data_out <= '0;
            rd_ack_out      <= '0;
            rd_data_out     <= '0;
        end else begin
            ram_wr_en_out <= wr_en_in;
            ram_rd_en_out <= rd_gnt;
            if (wr_en_in) begin
                ram_addr_out    <= wr_addr_in;
                ram_wr_data_out <= wr_data_in;
            end else if (rd_gnt) begin
                ram_addr_out <= {gnt_idx, rd_addr_in[gnt_idx*AW +: AW]};
            end
            if (rd_gnt)
                rr_ptr <= gnt_idx;

            // Stage 1 tags the cycle the RAM sees the command, stage 2 the
            // cycle its read data is on ram_rd_data_in.
            vld_pipe    <= {vld_pipe[1], rd_gnt};
            tag_pipe[1] <= gnt_idx;
            tag_pipe[2] <= tag_pipe[1];

            rd_ack_out <= vld_pipe[2] ? (CH_N'(1) << tag_pipe[2]) : '0;
            if (vld_pipe[2])
                rd_data_out <= ram_rd_data_in;
        end
    end
endmodule

// File: tb/tb_ws281x_ram_arb.sv
// Directed bench for ws281x_ram_arb with a behavioural registered-output RAM.

module tb_ws281x_ram_arb;
    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        wr_en_in = 1'b0;
    logic [7:0]  wr_addr_in = '0;
    logic [31:0] wr_data_in = '0;
    logic [3:0]  ch_en_in = '0;
    logic [3:0]  rd_req_in = '0;
    logic [23:0] rd_addr_in = '0;
    logic [3:0]  rd_ack_out;
    logic [31:0] rd_data_out;
    logic        ram_wr_en_out;
    logic        ram_rd_en_out;
    logic [7:0]  ram_addr_out;
    logic [31:0] ram_wr_data_out;
    logic [31:0] ram_rd_data_in;

    int vectors = 0;
    int errors  = 0;

    ws281x_ram_arb #(.CH_N(4), .AW(6), .DW(32)) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .wr_en_in        (wr_en_in),
        .wr_addr_in      (wr_addr_in),
        .wr_data_in      (wr_data_in),
        .ch_en_in        (ch_en_in),
        .rd_req_in       (rd_req_in),
        .rd_addr_in      (rd_addr_in),
        .rd_ack_out      (rd_ack_out),
        .rd_data_out     (rd_data_out),
        .ram_wr_en_out   (ram_wr_en_out),
        .ram_rd_en_out   (ram_rd_en_out),
        .ram_addr_out    (ram_addr_out),
        .ram_wr_data_out (ram_wr_data_out),
        .ram_rd_data_in  (ram_rd_data_in)
    );

    always #5 clk_in = ~clk_in;

    // RAM macro model: unwritten words read back a known default pattern.
    bit   [255:0] wrote;
    logic [31:0]  mem [256];

    function automatic logic [31:0] dflt(input logic [7:0] a);
        return (a == 8'h45) ? 32'h0012_3456 : (32'hA000_0000 | {24'h0, a});
    endfunction

    always @(posedge clk_in) begin
        if (ram_wr_en_out) begin
            mem[ram_addr_out]   <= ram_wr_data_out;
            wrote[ram_addr_out] <= 1'b1;
        end
        if (ram_rd_en_out)
            ram_rd_data_in <= wrote[ram_addr_out] ? mem[ram_addr_out] : dflt(ram_addr_out);
    end

    task automatic do_reset();
        rst_n_in  = 1'b0;
        wr_en_in  = 1'b0;
        rd_req_in = '0;
        ch_en_in  = '0;
        rd_addr_in = '0;
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if ({rd_ack_out, ram_wr_en_out, ram_rd_en_out} !== 6'b0) begin
            errors++; $display("FAIL reset_ctl: got %b want 000000", {rd_ack_out, ram_wr_en_out, ram_rd_en_out});
        end
        vectors++;
        if ({rd_data_out, ram_addr_out, ram_wr_data_out} !== 72'b0) begin
            errors++; $display("FAIL reset_data: got %h want 0", {rd_data_out, ram_addr_out, ram_wr_data_out});
        end
        do_reset();
        @(negedge clk_in);
        vectors++;
        if ({ram_wr_en_out, ram_rd_en_out} !== 2'b00) begin
            errors++; $display("FAIL reset_idle: got %b want 00", {ram_wr_en_out, ram_rd_en_out});
        end
    endtask

    task automatic test_single_read();
        do_reset();
        ch_en_in = 4'hF;
        rd_addr_in[6 +: 6] = 6'h05;
        rd_req_in = 4'b0010;
        @(negedge clk_in);
        vectors++;
        if (ram_rd_en_out !== 1'b1 || ram_wr_en_out !== 1'b0 || ram_addr_out !== 8'h45) begin
            errors++; $display("FAIL single_cmd: got rd=%b wr=%b addr=%h want rd=1 wr=0 addr=45", ram_rd_en_out, ram_wr_en_out, ram_addr_out);
        end
        @(negedge clk_in);
        vectors++;
        if (rd_ack_out !== 4'b0000) begin
            errors++; $display("FAIL single_early_ack: got %b want 0000", rd_ack_out);
        end
        @(negedge clk_in);
        vectors++;
        if (rd_ack_out !== 4'b0010 || rd_data_out !== 32'h0012_3456) begin
            errors++; $display("FAIL single_ack: got ack=%b data=%h want 0010 00123456", rd_ack_out, rd_data_out);
        end
        rd_req_in = '0;
        @(negedge clk_in);
        vectors++;
        if (rd_ack_out !== 4'b0000 || rd_data_out !== 32'h0012_3456 || ram_rd_en_out !== 1'b0) begin
            errors++; $display("FAIL single_hold: got ack=%b data=%h rd=%b want 0000 00123456 0", rd_ack_out, rd_data_out, ram_rd_en_out);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0]  exp_addr [4] = '{8'h01, 8'h42, 8'h83, 8'hC4};
        logic [31:0] exp_data [4] = '{32'hA000_0001, 32'hA000_0042, 32'hA000_0083, 32'hA000_00C4};
        do_reset();
        ch_en_in = 4'hF;
        for (int c = 0; c < 4; c++) rd_addr_in[c*6 +: 6] = 6'(c + 1);
        rd_req_in = 4'hF;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk_in);
            vectors++;
            if (ram_rd_en_out !== 1'b1 || ram_addr_out !== exp_addr[(k-1)%4]) begin
                errors++; $display("FAIL rr_grant[%0d]: got rd=%b addr=%h want 1 %h", k, ram_rd_en_out, ram_addr_out, exp_addr[(k-1)%4]);
            end
            if (k >= 3) begin
                vectors++;
                if (rd_ack_out !== 4'(1 << ((k-3)%4)) || rd_data_out !== exp_data[(k-3)%4]) begin
                    errors++; $display("FAIL rr_ack[%0d]: got ack=%b data=%h want %b %h", k, rd_ack_out, rd_data_out, 4'(1 << ((k-3)%4)), exp_data[(k-3)%4]);
                end
            end
        end
    endtask

    task automatic test_write_priority();
        do_reset();
        ch_en_in = 4'hF;
        rd_addr_in[0 +: 6]  = 6'h07;
        rd_addr_in[12 +: 6] = 6'h09;
        rd_req_in = 4'b0101;
        for (int k = 0; k < 3; k++) begin
            wr_en_in   = 1'b1;
            wr_addr_in = 8'h50 + 8'(k);
            wr_data_in = 32'hC0DE_0000 + 32'(k);
            @(negedge clk_in);
            vectors++;
            if (ram_wr_en_out !== 1'b1 || ram_rd_en_out !== 1'b0 ||
                ram_addr_out !== 8'h50 + 8'(k) || ram_wr_data_out !== 32'hC0DE_0000 + 32'(k)) begin
                errors++; $display("FAIL wr_prio[%0d]: got wr=%b rd=%b addr=%h data=%h want 1 0 %h %h", k,
                    ram_wr_en_out, ram_rd_en_out, ram_addr_out, ram_wr_data_out, 8'h50 + 8'(k), 32'hC0DE_0000 + 32'(k));
            end
        end
        wr_en_in = 1'b0;
        @(negedge clk_in);
        vectors++;
        if (ram_rd_en_out !== 1'b1 || ram_wr_en_out !== 1'b0 || ram_addr_out !== 8'h07) begin
            errors++; $display("FAIL wr_then_ch0: got rd=%b wr=%b addr=%h want 1 0 07", ram_rd_en_out, ram_wr_en_out, ram_addr_out);
        end
        @(negedge clk_in);
        vectors++;
        if (ram_rd_en_out !== 1'b1 || ram_addr_out !== 8'h89) begin
            errors++; $display("FAIL wr_then_ch2: got rd=%b addr=%h want 1 89", ram_rd_en_out, ram_addr_out);
        end
    endtask

    task automatic test_ch_enable();
        int bad_grants = 0;
        int good_grants = 0;
        int ch0_acks = 0;
        do_reset();
        ch_en_in = 4'b1011;
        for (int c = 0; c < 4; c++) rd_addr_in[c*6 +: 6] = 6'h10;
        rd_req_in = 4'hF;
        @(negedge clk_in);
        vectors++;
        if (ram_rd_en_out !== 1'b1 || ram_addr_out !== 8'h10) begin
            errors++; $display("FAIL en_first: got rd=%b addr=%h want 1 10", ram_rd_en_out, ram_addr_out);
        end
        ch_en_in = 4'b1010;
        for (int k = 2; k <= 16; k++) begin
            @(negedge clk_in);
            if (ram_rd_en_out && (ram_addr_out[7:6] == 2'd0 || ram_addr_out[7:6] == 2'd2)) bad_grants++;
            if (ram_rd_en_out && (ram_addr_out[7:6] == 2'd1 || ram_addr_out[7:6] == 2'd3)) good_grants++;
            if (rd_ack_out[0]) ch0_acks++;
            if (k == 3) begin
                vectors++;
                if (rd_ack_out !== 4'b0001) begin
                    errors++; $display("FAIL en_ch0_ack: got %b want 0001", rd_ack_out);
                end
            end
        end
        vectors++;
        if (bad_grants !== 0) begin
            errors++; $display("FAIL en_masked_grants: got %0d want 0", bad_grants);
        end
        vectors++;
        if (ch0_acks !== 1) begin
            errors++; $display("FAIL en_ch0_ack_count: got %0d want 1", ch0_acks);
        end
        vectors++;
        if (good_grants < 4) begin
            errors++; $display("FAIL en_live_grants: got %0d want >=4", good_grants);
        end
    endtask

    task automatic test_hazard();
        do_reset();
        ch_en_in   = 4'hF;
        wr_en_in   = 1'b1;
        wr_addr_in = 8'hFF;
        wr_data_in = 32'h0000_00AB;
        @(negedge clk_in);
        wr_en_in = 1'b0;
        rd_addr_in[18 +: 6] = 6'h3F;
        rd_req_in = 4'b1000;
        @(negedge clk_in);
        vectors++;
        if (ram_rd_en_out !== 1'b1 || ram_addr_out !== 8'hFF) begin
            errors++; $display("FAIL hazard_cmd: got rd=%b addr=%h want 1 ff", ram_rd_en_out, ram_addr_out);
        end
        repeat (2) @(negedge clk_in);
        vectors++;
        if (rd_ack_out !== 4'b1000 || rd_data_out !== 32'h0000_00AB) begin
            errors++; $display("FAIL hazard_data: got ack=%b data=%h want 1000 000000ab", rd_ack_out, rd_data_out);
        end
        rd_req_in = '0;
    endtask

    task automatic test_reset_midburst();
        do_reset();
        ch_en_in = 4'hF;
        for (int c = 0; c < 4; c++) rd_addr_in[c*6 +: 6] = 6'h20;
        rd_req_in = 4'hF;
        repeat (3) @(negedge clk_in);
        rst_n_in = 1'b0;
        #1;
        vectors++;
        if ({rd_ack_out, ram_wr_en_out, ram_rd_en_out} !== 6'b0 ||
            {rd_data_out, ram_addr_out, ram_wr_data_out} !== 72'b0) begin
            errors++; $display("FAIL midburst_clear: got ack=%b rd=%b data=%h addr=%h want all 0",
                rd_ack_out, ram_rd_en_out, rd_data_out, ram_addr_out);
        end
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(negedge clk_in);
        vectors++;
        if (rd_ack_out !== 4'b0000 || ram_rd_en_out !== 1'b1 || ram_addr_out !== 8'h20) begin
            errors++; $display("FAIL midburst_restart: got ack=%b rd=%b addr=%h want 0000 1 20", rd_ack_out, ram_rd_en_out, ram_addr_out);
        end
        @(negedge clk_in);
        vectors++;
        if (rd_ack_out !== 4'b0000) begin
            errors++; $display("FAIL midburst_stale_ack: got %b want 0000", rd_ack_out);
        end
        rd_req_in = '0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_priority();
        test_ch_enable();
        test_hazard();
        test_reset_midburst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/ws281x_ram_arb.md
# ws281x_ram_arb

Round-robin arbiter that shares one single-port, registered-output pixel RAM between a host write port and `CH_N` WS281x channel controllers. Each channel issues 6-bit word reads into its own bank. The arbiter grants at most one RAM operation per cycle. Host writes take absolute priority. Each read result returns to its requester with a one-cycle acknowledge. The block sits between the channel controllers and the shared RAM macro.

## Interface
- `CH_N`, 4: number of channels, 2..8; `CHW = $clog2(CH_N)`.
- `AW`, 6: per-channel word address width.
- `DW`, 32: RAM word width.
- `clk_in` in 1: clock.
- `rst_n_in` in 1: asynchronous, active-low reset.
- `wr_en_in` in 1: host write strobe, one word per cycle.
- `wr_addr_in` in CHW+AW: host write address, formatted as {bank, word}.
- `wr_data_in` in DW: host write data.
- `ch_en_in` in CH_N: per-channel enable; a 0 bit masks that channel from arbitration.
- `rd_req_in` in CH_N: per-channel read request (level).
- `rd_addr_in` in CH_N*AW: per-channel word address; channel i uses bits [i*AW +: AW].
- `rd_ack_out` out CH_N: one-hot, one-cycle pulse; `rd_data_out` is valid for that channel.
- `rd_data_out` out DW: read data, shared by all channels.
- `ram_wr_en_out` out 1: RAM write enable.
- `ram_rd_en_out` out 1: RAM read enable.
- `ram_addr_out` out CHW+AW: RAM address.
- `ram_wr_data_out` out DW: RAM write data.
- `ram_rd_data_in` in DW: RAM read data, valid the cycle after the read-enable cycle.

## Operation
- Eligible set: `rd_req_in & ch_en_in & ~pending`, evaluated each cycle.
- `pending[i]` means channel i has a read issued and not yet acknowledged.
- Decision each cycle, in priority order:
  - `wr_en_in` high: issue the host write. No read is granted this cycle.
  - Otherwise, eligible set non-zero: grant the first eligible channel found searching upward (with wrap) from `rr_ptr+1`. Then:
    - `rr_ptr` is set to the granted index.
    - `pending[granted]` is set.
    - A tag carrying the channel index enters a 2-stage pipeline.
  - Otherwise: idle. `ram_wr_en_out` and `ram_rd_en_out` are both 0.
- Read RAM address: `{granted index, rd_addr_in[granted]}`.
- Write RAM outputs: `wr_addr_in` and `wr_data_in` passed through unchanged.
- Reads pipeline: one grant per cycle is possible, with up to 3 reads (from distinct channels) in flight.
- `ram_wr_en_out` and `ram_rd_en_out` are never high in the same cycle.
- Requester contract:
  - Hold `rd_req_in[i]` and its address stable until the cycle the ack is seen.
  - Deassert or re-request (new address) from the following cycle.
- The arbiter never issues a second read for a channel while `pending[i]` is set.
- Clearing `ch_en_in[i]` while `pending[i]` is set: the in-flight read still completes and is acknowledged. New grants to channel i stop the same cycle.
- Write/read hazard: a write to a word issued the cycle before a read of the same word returns the new data. Reads are not reordered behind writes.
- Reset (asynchronous, at any time):
  - `pending`, the tag pipeline and all outputs go to 0.
  - `rr_ptr` goes to `CH_N-1`, so channel 0 wins first.
  - In-flight reads are dropped without an ack.

## Timing
- Grant decision in cycle t drives registered RAM outputs (`ram_*_out`) valid in t+1.
- RAM samples the command at the end of t+1; `ram_rd_data_in` is valid in t+2.
- `rd_data_out` and `rd_ack_out[tag]` are registered at the end of t+2, so they are valid in t+3.
- Read latency: request sampled in cycle t, ack in cycle t+3.
- `pending` is set at the end of t and cleared at the end of t+3.
- Earliest re-grant to the same channel is cycle t+4, so sustained per-channel rate is 1 read every 4 cycles.
- Aggregate rate is 1 read per cycle when at least 4 channels request.
- Write: `wr_en_in` in cycle t gives `ram_wr_en_out` in t+1. No back-pressure.
- `rd_data_out` holds its last value between acks.

## Test plan
- Channel 1 only, address 0x05, RAM word 0x0012_3456: `rd_req_in=4'b0010` at cycle t -> `ram_rd_en_out=1`, `ram_addr_out=8'h45` at t+1; `rd_ack_out=4'b0010`, `rd_data_out=0x0012_3456` at t+3.
- All four channels request continuously from reset -> grants in the order 0,1,2,3 in consecutive cycles; acks 4'b0001, 4'b0010, 4'b0100, 4'b1000 at t+3..t+6; channel 0 is re-granted at t+4.
- `wr_en_in` held high for 3 cycles while channels 0 and 2 request -> three `ram_wr_en_out` cycles with no read enable; channel 0 is granted on the cycle after the writes end, channel 2 on the next.
- `ch_en_in=4'b1011` with all channels requesting -> channel 2 is never granted. Clear `ch_en_in[0]` the cycle after channel 0's grant -> channel 0's ack still arrives at t+3 and channel 0 gets no further grants.
- Write 0xAB to {bank 3, word 0x3F}, then channel 3 reads word 0x3F on the next cycle -> `rd_data_out=0xAB`.
- Assert `rst_n_in=0` mid-burst with 3 reads in flight -> all outputs read 0 immediately and no ack appears afterwards; after release, channel 0 wins first.
